// File: rtl/snes_poller.sv
`timescale 1ns/1ps
// SNES controller reader: drives latch/clk strobes and deserialises the active-low data line.
// Optional SNES_POLL_CONNECT_DETECT_EN adds a trailing clock pulse to detect a plugged-in pad.
module snes_poller #(
  parameter int NUM_BITS     = 16,
  parameter int LATCH_CYCLES = 25,
  parameter int HALF_CYCLES  = 12,
  parameter int POLL_CYCLES  = 34667
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                poll_en,
  input  logic                start,
  input  logic                snes_data,
  output logic                snes_latch,
  output logic                snes_clk,
  output logic [NUM_BITS-1:0] buttons,
  output logic                valid,
  output logic                busy,
  output logic                connected
);

  localparam int CW = $clog2(LATCH_CYCLES > HALF_CYCLES ? LATCH_CYCLES : HALF_CYCLES);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int BW = $clog2(NUM_BITS + 1);
`ifdef SNES_POLL_CONNECT_DETECT_EN
  localparam int LAST_BIT = NUM_BITS;
`else
  localparam int LAST_BIT = NUM_BITS - 1;
`endif

  typedef enum logic [2:0] {IDLE, LATCH, GAP, CLK_LO, CLK_HI, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [PW-1:0]       poll_q, poll_d;
  logic [NUM_BITS-1:0] sr_q, sr_d;
  logic [NUM_BITS-1:0] buttons_q, buttons_d;
  logic                conn_q, conn_d;
  logic [1:0]          sync_q;
  logic                data_s;
  logic                poll_hit;
  logic                trigger;
`ifdef SNES_POLL_CONNECT_DETECT_EN
  logic                line_q, line_d;
`endif

  assign data_s   = sync_q[1];
  assign poll_hit = poll_en && (poll_q == PW'(POLL_CYCLES - 1));
  assign trigger  = (state_q == IDLE) && (start || poll_hit);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      poll_q    <= '0;
      sr_q      <= '0;
      buttons_q <= '0;
      conn_q    <= 1'b0;
      sync_q    <= 2'b11;
`ifdef SNES_POLL_CONNECT_DETECT_EN
      line_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      poll_q    <= poll_d;
      sr_q      <= sr_d;
      buttons_q <= buttons_d;
      conn_q    <= conn_d;
      sync_q    <= {sync_q[0], snes_data};
`ifdef SNES_POLL_CONNECT_DETECT_EN
      line_q    <= line_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    buttons_d = buttons_q;
`ifdef SNES_POLL_CONNECT_DETECT_EN
    conn_d    = conn_q;
    line_d    = line_q;
`else
    conn_d    = 1'b1;
`endif

    // The poll counter saturates while a frame runs so an overdue poll fires right after DONE.
    if (trigger)
      poll_d = '0;
    else if (poll_en && !poll_hit)
      poll_d = poll_q + 1'b1;
    else
      poll_d = poll_q;

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = LATCH;
          cnt_d   = CW'(LATCH_CYCLES - 1);
          bit_d   = '0;
        end
      end
      LATCH: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = CW'(HALF_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          sr_d    = {~data_s, sr_q[NUM_BITS-1:1]};
          bit_d   = BW'(1);
          state_d = (LAST_BIT == 0) ? DONE : CLK_LO;
          cnt_d   = CW'(HALF_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLK_LO: begin
        if (cnt_q == '0) begin
          state_d = CLK_HI;
          cnt_d   = CW'(HALF_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CLK_HI: begin
        if (cnt_q == '0) begin
`ifdef SNES_POLL_CONNECT_DETECT_EN
          if (bit_q < BW'(NUM_BITS))
            sr_d = {~data_s, sr_q[NUM_BITS-1:1]};
          else
            line_d = data_s;
`else
          sr_d = {~data_s, sr_q[NUM_BITS-1:1]};
`endif
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BW'(LAST_BIT)) ? DONE : CLK_LO;
          cnt_d   = CW'(HALF_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        buttons_d = sr_q;
`ifdef SNES_POLL_CONNECT_DETECT_EN
        conn_d    = ~line_q;
`endif
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign snes_latch = (state_q == LATCH);
  assign snes_clk   = (state_q != CLK_LO);
  assign valid      = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign buttons    = buttons_q;
  assign connected  = conn_q;

endmodule

// File: tb/tb_snes_poller.sv
`timescale 1ns/1ps
// Scoreboard bench for snes_poller: pad model on the serial line, expected frames queued by stimulus.
module tb_snes_poller;
  localparam int NB = 16;
`ifdef SNES_POLL_CONNECT_DETECT_EN
  localparam int DONE_OFF = 422;
  localparam int NFALL    = 16;
  localparam bit DET      = 1'b1;
`else
  localparam int DONE_OFF = 398;
  localparam int NFALL    = 15;
  localparam bit DET      = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, poll_en, start, snes_data;
  logic snes_latch, snes_clk, valid, busy, connected;
  logic [NB-1:0] buttons;

  snes_poller dut (
    .clock(clock), .reset(reset), .poll_en(poll_en), .start(start),
    .snes_data(snes_data), .snes_latch(snes_latch), .snes_clk(snes_clk),
    .buttons(buttons), .valid(valid), .busy(busy), .connected(connected)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Pad model: bit 0 presented during latch, advances on each snes_clk rising edge.
  logic [NB-1:0] pat = '0;
  logic          present = 1'b1;
  logic [4:0]    idx = 5'd16;
  logic          pad_pclk = 1'b1;
  always @(negedge clock) begin
    if (snes_latch) idx = 5'd0;
    else if (snes_clk && !pad_pclk && !idx[4]) idx = idx + 5'd1;
    pad_pclk = snes_clk;
  end
  assign snes_data = !present ? 1'b1 : (!idx[4] ? ~pat[idx[3:0]] : 1'b0);

  // Frame shape tracker.
  int   lat_start = -1, lat_len = 0, falls = 0;
  logic plat = 1'b0, pclk_m = 1'b1;
  always @(negedge clock) begin
    if (snes_latch && !plat) begin
      lat_start = cyc;
      lat_len   = 0;
      falls     = 0;
    end
    if (snes_latch) lat_len++;
    if (!snes_clk && pclk_m) falls++;
    plat   = snes_latch;
    pclk_m = snes_clk;
  end

  logic idle_watch = 1'b0;
  int   idle_bad = 0;
  always @(negedge clock)
    if (idle_watch && (snes_latch !== 1'b0 || snes_clk !== 1'b1 || busy !== 1'b0))
      idle_bad++;

  typedef struct {
    int            trig;
    logic [NB-1:0] btn;
    logic          conn;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  always @(negedge clock) begin
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: valid=1 at cycle %0d, required no pulse", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.trig + DONE_OFF);
        chk("latch_start", lat_start, e.trig + 1);
        chk("latch_len", lat_len, 25);
        chk("clk_falls", falls, NFALL);
        chk("busy_at_done", 32'(busy), 1);
        @(negedge clock);
        chk("buttons", 32'(buttons), 32'(e.btn));
        chk("connected", 32'(connected), 32'(e.conn));
        chk("busy_after_done", 32'(busy), 0);
        chk("valid_one_cycle", 32'(valid), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int trig, input logic [NB-1:0] btn, input logic conn);
    exp_t x;
    x.trig = trig;
    x.btn  = btn;
    x.conn = conn;
    exp_q.push_back(x);
  endtask

  task automatic drain(input string nm, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    chk(nm, exp_q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int t0;
  initial begin
    reset = 1'b1; poll_en = 1'b0; start = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    chk("rst_latch", 32'(snes_latch), 0);
    chk("rst_clk", 32'(snes_clk), 1);
    chk("rst_buttons", 32'(buttons), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_connected", 32'(connected), 0);
    tick();
    reset = 1'b0;

    idle_watch = 1'b1;
    repeat (1000) tick();
    idle_watch = 1'b0;
    @(negedge clock);
    chk("idle_strobes", idle_bad, 0);
    chk("idle_buttons", 32'(buttons), 0);
    chk("idle_connected", 32'(connected), DET ? 0 : 1);

    // Single start-triggered frame.
    tick();
    t0 = cyc; pat = 16'hA5C3; start = 1'b1;
    push(t0, 16'hA5C3, 1'b1);
    tick();
    start = 1'b0;
    @(negedge clock);
    chk("busy_after_trigger", 32'(busy), 1);
    drain("frame_a5c3", 600);

    // Auto-poll: start launches frame 1 and clears the counter; frame 2 follows POLL_CYCLES later.
    tick();
    t0 = cyc; pat = 16'h0001; poll_en = 1'b1; start = 1'b1;
    push(t0, 16'h0001, 1'b1);
    push(t0 + 34667, 16'h8000, 1'b1);
    tick();
    start = 1'b0;
    begin
      int k = 0;
      while (exp_q.size() > 1 && k < 600) begin tick(); k++; end
    end
    repeat (3) tick();
    pat = 16'h8000;
    drain("poll_frames", 35000);
    poll_en = 1'b0;

    // Reset in cycle 200 of a frame.
    tick();
    t0 = cyc; pat = 16'hFFFF; start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < t0 + 200) tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk("midrst_latch", 32'(snes_latch), 0);
    chk("midrst_clk", 32'(snes_clk), 1);
    chk("midrst_buttons", 32'(buttons), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(valid), 0);
    chk("midrst_connected", 32'(connected), 0);
    tick();
    reset = 1'b0;
    repeat (600) tick();
    chk("midrst_buttons_hold", 32'(buttons), 0);

    // Start held high: back-to-back frames, no restart while busy.
    tick();
    t0 = cyc; pat = 16'h1234; start = 1'b1;
    push(t0, 16'h1234, 1'b1);
    push(t0 + DONE_OFF + 1, 16'h1234, 1'b1);
    while (cyc < t0 + DONE_OFF + 3) tick();
    start = 1'b0;
    drain("held_start", 1000);
    repeat (500) tick();

    // Pad unplugged: line stays high.
    tick();
    t0 = cyc; present = 1'b0; start = 1'b1;
    push(t0, 16'h0000, DET ? 1'b0 : 1'b1);
    tick();
    start = 1'b0;
    drain("unplugged", 600);

    // Pad plugged back in.
    tick();
    t0 = cyc; present = 1'b1; pat = 16'h5A5A; start = 1'b1;
    push(t0, 16'h5A5A, 1'b1);
    tick();
    start = 1'b0;
    drain("replugged", 600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
